fixed_to_float_packer: RTL and testbench
========================================

Name: fixed_to_float_packer

Overview:
- Converts a signed two's-complement fixed-point value, as produced by the CORDIC datapath and by the float-to-fixed unpacker, back to an IEEE-754 single-precision word.
- Sits at the output of the CORDIC core, mirroring the unpacker at its input.
- The output is registered, giving one cycle of latency with a valid strobe.

Parameters:
- WIDTH, 22, number of fractional bits of the fixed input. Legal range 1..60.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, the fixed input is valid this cycle.
- fixed, input, WIDTH+2, two's complement. Value = fixed / 2^WIDTH, so the range is [-2, 2).
- out_valid, output, 1, result is valid.
- result, output, 32, IEEE-754 single: {sign, exp[7:0], mant[22:0]}.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - result <= 32'h0 and out_valid <= 0.
  - rst has priority over in_valid in the same cycle.
  - Any conversion accepted in the reset cycle is discarded.
- Latency and handshake:
  - Exactly 1 cycle: fixed sampled with in_valid=1 at edge N appears on result with out_valid=1 after edge N.
  - out_valid follows in_valid delayed by one cycle; there is no backpressure.
  - While in_valid=0, result holds its last value and out_valid=0.
- Conversion (combinational, ahead of the output register):
  - sign = fixed[WIDTH+1].
  - mag = |fixed| as an unsigned WIDTH+2-bit value. The most negative input (-2.0) gives mag = 2^(WIDTH+1), which fits without overflow.
  - mag == 0 -> result = 32'h00000000 (+0). Negative zero is never produced.
  - Otherwise:
    - p = index of the most significant 1 in mag, 0..WIDTH+1.
    - exp = 127 + p - WIDTH.
    - mant = bits mag[p-1:0] left-aligned into 23 bits, zero-filled on the right.
    - If p > 23, keep only the top 23 bits below the leading one. Rounding is truncation (toward zero).
  - Denormals, Inf and NaN are never generated, because exp stays within 1..254 for legal WIDTH.
- For WIDTH=22, every input converts exactly (p ≤ 23). The block is the exact inverse of the unpacker on any value the unpacker can represent.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP_EXP_BIAS=127, FP_EXP_W=8, FP_MANT_W=23;
  - a packed struct typedef fp32_t {sign, exp, mant};
  - a helper function for the fixed value width (WIDTH+2).
- Sub-module leading_one_detect (parameter N):
  - outputs the index of the most significant set bit and a found flag;
  - used by the normaliser.
  - The unpacker reuses fp_pkg.

Test Plan (WIDTH=22; each result checked 1 cycle after in_valid):
- Sign cases:
  - fixed=24'h400000 (+1.0) -> 32'h3f800000.
  - fixed=24'hC00000 (-1.0) -> 32'hbf800000.
  - fixed=24'h200000 (0.5) -> 32'h3f000000.
- Round-trip of unpacked mantissas:
  - fixed=24'h31EB85 (0.78 truncated) -> 32'h3f47ae14.
  - fixed=24'h22A565 -> 32'h3f0a9594.
- Extremes:
  - fixed=24'h000000 -> 32'h00000000.
  - fixed=24'h800000 (-2.0) -> 32'hc0000000.
  - fixed=24'h000001 (2^-22) -> 32'h34800000.
- Control:
  - rst asserted while in_valid=1 -> next cycle out_valid=0, result=0.
  - Back-to-back in_valid for 4 cycles -> 4 consecutive correct results.
  - in_valid low -> result held, out_valid=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the fixed<->float
// packer/unpacker pair around the CORDIC core.
package fp_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MANT_W   = 23;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  // Full width of a fixed value: sign bit, one integer bit, WIDTH fraction bits.
  function automatic int fixed_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Reports the index of the most significant set bit of a vector.
module leading_one_detect #(
  parameter int N  = 24,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Ascending scan: the last hit wins, which is the highest set bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_to_float_packer.sv
// Signed fixed-point (value = fixed / 2^WIDTH, range [-2,2)) to IEEE-754
// single. One registered cycle of latency; mantissa is truncated.
module fixed_to_float_packer
  import fp_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH+1:0] fixed,
  output logic             out_valid,
  output logic [31:0]      result
);

  localparam int FW = fixed_w(WIDTH);
  localparam int PW = $clog2(FW);

  logic          sign;
  logic [FW-1:0] mag;
  logic [PW-1:0] p;
  logic          found;
  logic [PW-1:0] sh;
  logic [FW-1:0] norm;
  logic [FW-2+FP_MANT_W:0] ext;
  logic          unused_bits;
  fp32_t         conv;

  fp32_t result_d, result_q;
  logic  out_valid_d, out_valid_q;

  // Magnitude; -2.0 maps to 2^(WIDTH+1), which still fits in FW unsigned bits.
  always_comb begin
    sign = fixed[FW-1];
    mag  = sign ? (~fixed + FW'(1)) : fixed;
  end

  leading_one_detect #(.N(FW), .IW(PW)) u_lod (
    .vec   (mag),
    .idx   (p),
    .found (found)
  );

  // Normalise the leading one to the top bit, then take the bits below it,
  // zero-filling on the right when fewer than 23 fraction bits exist.
  always_comb begin
    sh   = PW'(FW - 1) - p;
    norm = mag << sh;
    ext  = {norm[FW-2:0], {FP_MANT_W{1'b0}}};
    conv = '0;
    if (found) begin
      conv.sign = sign;
      conv.exp  = FP_EXP_W'(FP_EXP_BIAS + int'(p) - WIDTH);
      conv.mant = ext[FW-2+FP_MANT_W -: FP_MANT_W];
    end
  end

  // Leading one and bits below the truncation point are dropped by design.
  assign unused_bits = ^{norm[FW-1], ext[FW-2:0]};

  // Next-state: load a new conversion on in_valid, otherwise hold the result.
  always_comb begin
    out_valid_d = in_valid;
    result_d    = in_valid ? conv : result_q;
  end

  // Output register; reset wins over a same-cycle conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_to_float_packer.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge
// monitor pops and compares whenever the DUT presents out_valid.
module tb_fixed_to_float_packer;

  localparam int WIDTH = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] fixed = '0;
  logic        out_valid;
  logic [31:0] result;

  logic [31:0] exp_in = '0;
  logic [31:0] sb_q[$];
  logic        exp_v = 1'b0;
  logic [31:0] exp_held = '0;
  logic        mon_en = 1'b0;
  logic        done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  fixed_to_float_packer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .fixed     (fixed),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference timing: what out_valid and the held result should be next cycle.
  always @(posedge clk) begin
    if (rst) begin
      exp_v    <= 1'b0;
      exp_held <= 32'h0;
    end else if (in_valid) begin
      exp_v    <= 1'b1;
      exp_held <= exp_in;
      sb_q.push_back(exp_in);
    end else begin
      exp_v    <= 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] e;
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_v, $time);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got %h want <none> at %0t", result, $time);
        end else begin
          e = sb_q.pop_front();
          if (result !== e) begin
            errors++;
            $display("FAIL result: got %h want %h at %0t", result, e, $time);
          end
        end
      end else begin
        checks++;
        if (result !== exp_held) begin
          errors++;
          $display("FAIL result_hold: got %h want %h at %0t", result, exp_held, $time);
        end
      end
    end
  end

  task automatic send(input logic [23:0] f, input logic [31:0] e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    fixed    = f;
    exp_in   = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      fixed    = 24'h5A5A5A;
    end
  endtask

  initial begin
    // Reset, with the monitor watching the reset state.
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Sign cases
    send(24'h400000, 32'h3f800000); idle(1);
    send(24'hC00000, 32'hbf800000); idle(1);
    send(24'h200000, 32'h3f000000); idle(2);
    // Round-trip mantissas
    send(24'h31EB85, 32'h3f47ae14); idle(1);
    send(24'h22A565, 32'h3f0a9594); idle(1);
    // Extremes
    send(24'h000000, 32'h00000000); idle(1);
    send(24'h800000, 32'hc0000000); idle(1);
    send(24'h000001, 32'h34800000); idle(1);
    send(24'h7FFFFF, 32'h3ffffffe); idle(1);
    send(24'hFFFFFF, 32'hb4800000); idle(1);
    // Back-to-back, then idle hold
    send(24'hE00000, 32'hbf000000);
    send(24'h600000, 32'h3fc00000);
    send(24'h000000, 32'h00000000);
    send(24'h31EB85, 32'h3f47ae14);
    idle(3);
    // Reset while in_valid=1: conversion must be discarded
    send(24'h400000, 32'h3f800000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    idle(2);
    send(24'hC00000, 32'hbf800000); idle(3);

    @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    done = 1'b1;
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
